median3x3_scanner: RTL and testbench



---
 rtl/median_pkg.sv | 25 ++
 rtl/line_buffer.sv | 27 ++
 rtl/median3x3_scanner.sv | 145 ++++++++++++++
 tb/tb_median3x3_scanner.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/median_pkg.sv
// Shared defaults, FSM encoding and the window popcount for the 3x3 binary median scanner.
package median_pkg;

    localparam int IMWIDTH_DEF  = 240;
    localparam int IMHEIGHT_DEF = 180;
    localparam int THRESH_DEF   = 5;
    localparam int CW           = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic [3:0] popcount9(input logic [8:0] b);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < 9; i++) begin
            cnt = cnt + {3'b000, b[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// One-bit shift register of LEN taps; the output is the bit shifted in LEN enables ago.
module line_buffer #(
    parameter int LEN = 241
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    input  logic i_din,
    output logic o_dout
);

    logic [LEN-1:0] r_sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr <= '0;
        end else if (i_clr) begin
            r_sr <= '0;
        end else if (i_en) begin
            r_sr <= {r_sr[LEN-2:0], i_din};
        end
    end

    assign o_dout = r_sr[LEN-1];

endmodule

// File: rtl/median3x3_scanner.sv
// Raster-scans a 1-bit image with one zero pad column/row and streams a 3x3 majority filter.
module median3x3_scanner
    import median_pkg::*;
#(
    parameter int IMWIDTH  = IMWIDTH_DEF,
    parameter int IMHEIGHT = IMHEIGHT_DEF,
    parameter int THRESH   = THRESH_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] xAddr,
    output logic [CW-1:0] yAddr,
    input  logic          pixelIn,
    output logic          outValid,
    output logic          outPixel,
    output logic [CW-1:0] outX,
    output logic [CW-1:0] outY
);

    localparam logic [CW-1:0] W_C = CW'(IMWIDTH);
    localparam logic [CW-1:0] H_C = CW'(IMHEIGHT);
    localparam logic [3:0]    T_C = 4'(THRESH);

    state_t        r_state, w_next;
    logic [CW-1:0] r_vx, r_vy;
    logic          r_drain;
    logic          w_start_acc, w_row_end, w_mem;

    // Sample in flight: address issued last cycle, pixelIn valid this cycle
    logic          r_p_vld, r_p_pad, r_p_out;
    logic [CW-1:0] r_p_x, r_p_y;

    logic          w_smp, w_top, w_mid;
    logic [2:0]    r_wl, r_wm, w_col;
    logic [3:0]    w_cnt;

    assign w_start_acc = (r_state == IDLE) && start;
    assign w_row_end   = (r_vx == W_C);
    assign w_mem       = (r_state == SCAN) && (r_vx < W_C) && (r_vy < H_C);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  if (start) w_next = SCAN;
            SCAN:  if (w_row_end && (r_vy == H_C)) w_next = DRAIN;
            DRAIN: if (r_drain) w_next = DONE;
            DONE:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vx    <= '0;
            r_vy    <= '0;
            r_drain <= 1'b0;
        end else begin
            r_drain <= (r_state == DRAIN);
            if (w_start_acc) begin
                r_vx <= '0;
                r_vy <= '0;
            end else if (r_state == SCAN) begin
                if (w_row_end) begin
                    r_vx <= '0;
                    r_vy <= r_vy + 1'b1;
                end else begin
                    r_vx <= r_vx + 1'b1;
                end
            end
        end
    end

    assign busy  = (r_state == SCAN) || (r_state == DRAIN);
    assign done  = (r_state == DONE);
    assign xAddr = w_mem ? r_vx : '0;
    assign yAddr = w_mem ? r_vy : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p_vld <= 1'b0;
            r_p_pad <= 1'b0;
            r_p_out <= 1'b0;
            r_p_x   <= '0;
            r_p_y   <= '0;
        end else begin
            r_p_vld <= (r_state == SCAN);
            r_p_pad <= !w_mem;
            r_p_out <= (r_state == SCAN) && (r_vx != '0) && (r_vy != '0);
            r_p_x   <= r_vx - 1'b1;
            r_p_y   <= r_vy - 1'b1;
        end
    end

    assign w_smp = r_p_vld && !r_p_pad && pixelIn;

    line_buffer #(.LEN(IMWIDTH + 1)) u_lb_mid (
        .clk(clk), .rst(rst), .i_clr(w_start_acc), .i_en(r_p_vld),
        .i_din(w_smp), .o_dout(w_mid)
    );

    line_buffer #(.LEN(IMWIDTH + 1)) u_lb_top (
        .clk(clk), .rst(rst), .i_clr(w_start_acc), .i_en(r_p_vld),
        .i_din(w_mid), .o_dout(w_top)
    );

    // The newest column is used combinationally so the result registers with the sample
    assign w_col = {w_top, w_mid, w_smp};
    assign w_cnt = popcount9({r_wl, r_wm, w_col});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wl <= '0;
            r_wm <= '0;
        end else if (w_start_acc) begin
            r_wl <= '0;
            r_wm <= '0;
        end else if (r_p_vld) begin
            r_wl <= r_wm;
            r_wm <= w_col;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outValid <= 1'b0;
            outPixel <= 1'b0;
            outX     <= '0;
            outY     <= '0;
        end else begin
            outValid <= r_p_vld && r_p_out;
            outPixel <= r_p_vld && r_p_out && (w_cnt >= T_C);
            outX     <= (r_p_vld && r_p_out) ? r_p_x : '0;
            outY     <= (r_p_vld && r_p_out) ? r_p_y : '0;
        end
    end

endmodule

// File: tb/tb_median3x3_scanner.sv
// Scoreboarded frame scans of a reduced-size image plus spot-check table and reset/start corner cases.
module tb_median3x3_scanner;

    localparam int W = 64;
    localparam int H = 66;
    localparam int N = (W + 1) * (H + 1);

    logic       clk, rst, start, busy, done, pixelIn, outValid, outPixel;
    logic [7:0] xAddr, yAddr, outX, outY;

    median3x3_scanner #(.IMWIDTH(W), .IMHEIGHT(H), .THRESH(5)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .xAddr(xAddr), .yAddr(yAddr), .pixelIn(pixelIn),
        .outValid(outValid), .outPixel(outPixel), .outX(outX), .outY(outY)
    );

    typedef struct {int x; int y; logic p;} item_t;
    typedef struct {int scn; int x; int y; logic exp;} spot_t;

    logic   img [H][W];
    logic   cap [H][W];
    item_t  sb[$];
    item_t  it;
    spot_t  spots[$];
    int     vectors = 0, fails = 0;
    int     cyc = 0, n_out = 0, n_done = 0, out0 = 0, done0 = 0, first_cyc = 0, k = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // imageROM model: one cycle read latency
    always @(posedge clk)
        pixelIn <= (int'(yAddr) < H && int'(xAddr) < W) ? img[int'(yAddr)][int'(xAddr)] : 1'b0;

    function automatic logic exp_px(input int x, input int y);
        int c = 0;
        for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++)
                if (x + dx >= 0 && x + dx < W && y + dy >= 0 && y + dy < H)
                    if (img[y + dy][x + dx] === 1'b1) c++;
        return c >= 5;
    endfunction

    always @(negedge clk) begin
        if (done) n_done++;
        if (outValid) begin
            n_out++;
            vectors++;
            if (n_out - out0 == 1) first_cyc = cyc;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL sb_extra got (%0d,%0d)=%0b, want no output", outX, outY, outPixel);
            end else begin
                it = sb.pop_front();
                if (int'(outX) != it.x || int'(outY) != it.y || outPixel !== it.p) begin
                    fails++;
                    $display("FAIL sb_out got (%0d,%0d)=%0b want (%0d,%0d)=%0b",
                             outX, outY, outPixel, it.x, it.y, it.p);
                end
            end
            if (int'(outX) < W && int'(outY) < H) cap[int'(outY)][int'(outX)] = outPixel;
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic outs_zero(input string name);
        check(name, {busy, done, xAddr, yAddr, outValid, outPixel, outX, outY}, 64'd0);
    endtask

    task automatic load(input int scn);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                case (scn)
                    1:       img[y][x] = 1'b1;
                    2:       img[y][x] = ((x == 10 && y == 10) || (x == W - 1 && y == 0));
                    3:       img[y][x] = (x >= 50 && x <= 52 && y >= 60 && y <= 62);
                    4:       img[y][x] = 1'($urandom_range(0, 1));
                    default: img[y][x] = 1'b0;
                endcase
            end
    endtask

    task automatic start_frame();
        sb.delete();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                cap[y][x] = 1'bx;
                sb.push_back('{x, y, exp_px(x, y)});
            end
        out0  = n_out;
        done0 = n_done;
        @(negedge clk);
        start = 1'b1;
        k = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);
    endtask

    task automatic wait_done(input bit poke);
        bit got = 1'b0;
        for (int i = 0; i < N + 50; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                start = poke;
                break;
            end
            start = poke && (i % 1000 == 7);
        end
        check("done_seen", 64'(got), 64'd1);
        check("done_cycle", 64'(cyc - k), 64'(N + 2));
        check("busy_in_done", 64'(busy), 64'd0);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("out_count", 64'(n_out - out0), 64'(W * H));
        check("sb_empty", 64'(sb.size()), 64'd0);
        check("done_count", 64'(n_done - done0), 64'd1);
        check("first_out_cycle", 64'(first_cyc - k), 64'(W + 4));
        check("idle_after", 64'({busy, outValid}), 64'd0);
    endtask

    task automatic spot(input int scn);
        foreach (spots[i])
            if (spots[i].scn == scn) begin
                vectors++;
                if (cap[spots[i].y][spots[i].x] !== spots[i].exp) begin
                    fails++;
                    $display("FAIL spot s%0d (%0d,%0d) got %0b want %0b", scn,
                             spots[i].x, spots[i].y, cap[spots[i].y][spots[i].x], spots[i].exp);
                end
            end
    endtask

    initial begin
        int c;
        bit hit;
        spots.push_back('{0, 0, 0, 1'b0});
        spots.push_back('{0, W - 1, H - 1, 1'b0});
        spots.push_back('{1, 0, 0, 1'b0});
        spots.push_back('{1, W - 1, H - 1, 1'b0});
        spots.push_back('{1, W - 1, 0, 1'b0});
        spots.push_back('{1, 0, H - 1, 1'b0});
        spots.push_back('{1, 5, 0, 1'b1});
        spots.push_back('{1, 0, 33, 1'b1});
        spots.push_back('{1, 32, 33, 1'b1});
        spots.push_back('{2, 10, 10, 1'b0});
        spots.push_back('{2, W - 1, 0, 1'b0});
        spots.push_back('{2, 9, 9, 1'b0});
        spots.push_back('{3, 51, 61, 1'b1});
        spots.push_back('{3, 50, 60, 1'b0});
        spots.push_back('{3, 51, 60, 1'b1});
        spots.push_back('{3, 49, 61, 1'b0});
        spots.push_back('{3, 52, 62, 1'b0});
        spots.push_back('{3, 51, 62, 1'b1});

        rst = 1'b1;
        start = 1'b0;
        load(0);
        repeat (3) @(negedge clk);
        outs_zero("reset_hold");
        rst = 1'b0;
        @(negedge clk);
        outs_zero("reset_release");

        for (int s = 0; s < 4; s++) begin
            load(s);
            start_frame();
            wait_done(1'b0);
            spot(s);
        end

        // Abort at the 1000th output, then a clean all-ones frame
        load(1);
        start_frame();
        c = 0;
        hit = 1'b0;
        for (int i = 0; i < N; i++) begin
            @(posedge clk);
            #2;
            if (outValid) begin
                c++;
                if (c == 1000) begin
                    hit = 1'b1;
                    break;
                end
            end
        end
        check("reach_out_1000", 64'(hit), 64'd1);
        done0 = n_done;
        rst = 1'b1;
        #1;
        outs_zero("async_abort");
        repeat (5) @(negedge clk);
        outs_zero("abort_hold");
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("no_done_after_abort", 64'(n_done - done0), 64'd0);
        start_frame();
        wait_done(1'b0);
        spot(1);

        // Random frame with start pulses mid-scan and in the done cycle
        load(4);
        start_frame();
        wait_done(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
